// File: rtl/twp_rim_regfile_pkg.sv
// Shared definitions for the two-master configuration register file.
package twp_rim_regfile_pkg;

  // TWP serial-slave states
  typedef logic [2:0] twp_state_t;
  localparam twp_state_t TWP_IDLE   = 3'd0;
  localparam twp_state_t TWP_CMD    = 3'd1;
  localparam twp_state_t TWP_ADDR   = 3'd2;
  localparam twp_state_t TWP_DATA   = 3'd3;
  localparam twp_state_t TWP_COMMIT = 3'd4;
  localparam twp_state_t TWP_TA     = 3'd5;
  localparam twp_state_t TWP_RSTART = 3'd6;
  localparam twp_state_t TWP_RDATA  = 3'd7;

  // RIM parallel-handshake states
  typedef logic [1:0] rim_state_t;
  localparam rim_state_t RIM_IDLE = 2'd0;
  localparam rim_state_t RIM_RDY  = 2'd1;
  localparam rim_state_t RIM_EX   = 2'd2;

  // Command bit encoding, shared by both masters
  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  // Largest of three counts; sizes the shared TWP bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/twp_rim_regfile_edge_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL rising edges.
module twp_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic srise,
  output logic sda_sync
);

  logic scl_s1, scl_s2;
  logic sda_s1, sda_s2;

  // Two-stage synchronisers; reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
    end
  end

  assign srise    = scl_s1 & ~scl_s2;
  assign sda_sync = sda_s2;

endmodule

// File: rtl/twp_rim_regfile.sv
// DEPTH x DATA_W register file shared by a parallel RIM master and a serial TWP master.
//
// TWP state | meaning
// IDLE      | waiting for start bit (SDA low at SCL rise)
// CMD       | capture command bit
// ADDR      | shift in ADDR_W address bits, LSB first
// DATA      | shift in DATA_W write bits, LSB first
// COMMIT    | single clk cycle: write register unless a RIM conflict drops it
// TA        | read turnaround, TA_CYC SCL rises
// RSTART    | drive response start bit (0)
// RDATA     | drive DATA_W read bits, LSB first
//
// RIM state | meaning
// IDLE      | waiting for cfg_req
// RDY       | request latched, write commits leaving this state
// EX        | read data presented on cfg_rdata
module twp_rim_regfile
  import twp_rim_regfile_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int TA_CYC   = 2,
  parameter int PRIO_RIM = 1,
  parameter int TO_CYC   = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              SCL,
  inout  wire               SDA,
  input  logic              cfg_req,
  output logic              cfg_rdy,
  input  logic              cfg_cmd,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              twp_busy,
  output logic              twp_abort
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = $clog2(max3(ADDR_W, DATA_W, TA_CYC)) + 1;
  localparam int TO_W  = $clog2(TO_CYC) + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic srise, sda_in;

  twp_state_t        twp_state;
  logic              twp_cmd;
  logic [ADDR_W-1:0] twp_addr;
  logic [DATA_W-1:0] twp_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              conflict;
  logic              sda_oe, sda_out;

  rim_state_t        rim_state;
  logic              rim_cmd;
  logic [ADDR_W-1:0] rim_addr;
  logic [DATA_W-1:0] rim_wdata;
  logic [ADDR_W-1:0] rim_last_addr;
  logic              rim_last_vld;

  logic              rim_wr, twp_wr, to_hit, frame_start, addr_hit;
  logic [ADDR_W-1:0] addr_next;

  twp_edge_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (SCL),
    .sda      (SDA),
    .srise    (srise),
    .sda_sync (sda_in)
  );

  assign SDA      = sda_oe ? sda_out : 1'bz;
  assign twp_busy = (twp_state != TWP_IDLE);
  assign cfg_rdy  = (rim_state == RIM_RDY) || (rim_state == RIM_EX);

  assign rim_wr      = (rim_state == RIM_RDY) && (rim_cmd == CMD_WR);
  assign twp_wr      = (twp_state == TWP_COMMIT) && !((PRIO_RIM != 0) && conflict);
  assign frame_start = (twp_state == TWP_IDLE) && srise && !sda_in;
  assign addr_next   = {sda_in, twp_addr[ADDR_W-1:1]};
  // A RIM write landing on the same edge as the last address bit also counts as a hit.
  assign addr_hit    = (rim_last_vld && (rim_last_addr == addr_next)) ||
                       (rim_wr && (rim_addr == addr_next));
  // COMMIT lasts one cycle and never waits on SCL, so it is exempt from the timeout.
  assign to_hit      = (twp_state != TWP_IDLE) && (twp_state != TWP_COMMIT) && !srise &&
                       (to_cnt == TO_W'(TO_CYC - 1));

  // Register array: the later assignment wins, so the priority master is written last.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (PRIO_RIM != 0) begin
        if (twp_wr) mem[twp_addr] <= twp_shift;
        if (rim_wr) mem[rim_addr] <= rim_wdata;
      end else begin
        if (rim_wr) mem[rim_addr] <= rim_wdata;
        if (twp_wr) mem[twp_addr] <= twp_shift;
      end
    end
  end

  // RIM handshake FSM: latch request, commit write, present read data for one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rim_state <= RIM_IDLE;
      rim_cmd   <= CMD_RD;
      rim_addr  <= '0;
      rim_wdata <= '0;
      cfg_rdata <= '0;
    end else begin
      case (rim_state)
        RIM_IDLE: begin
          cfg_rdata <= '0;
          if (cfg_req) begin
            rim_cmd   <= cfg_cmd;
            rim_addr  <= cfg_addr;
            rim_wdata <= cfg_wdata;
            rim_state <= RIM_RDY;
          end
        end
        RIM_RDY: begin
          if (rim_cmd == CMD_RD) cfg_rdata <= mem[rim_addr];
          rim_state <= RIM_EX;
        end
        RIM_EX: begin
          cfg_rdata <= '0;
          rim_state <= RIM_IDLE;
        end
        default: begin
          cfg_rdata <= '0;
          rim_state <= RIM_IDLE;
        end
      endcase
    end
  end

  // Last RIM write address since the current frame's start bit, for conflict detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rim_last_addr <= '0;
      rim_last_vld  <= 1'b0;
    end else if (rim_wr) begin
      rim_last_addr <= rim_addr;
      rim_last_vld  <= 1'b1;
    end else if (frame_start) begin
      rim_last_vld  <= 1'b0;
    end
  end

  // TWP serial FSM, advanced on SCL rises, with the mid-frame timeout abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      twp_state <= TWP_IDLE;
      twp_cmd   <= CMD_RD;
      twp_addr  <= '0;
      twp_shift <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      conflict  <= 1'b0;
      sda_oe    <= 1'b0;
      sda_out   <= 1'b0;
      twp_abort <= 1'b0;
    end else begin
      twp_abort <= 1'b0;
      if ((twp_state == TWP_IDLE) || srise) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;

      if ((twp_state == TWP_DATA) && rim_wr && (rim_addr == twp_addr)) conflict <= 1'b1;

      if (to_hit) begin
        twp_state <= TWP_IDLE;
        sda_oe    <= 1'b0;
        conflict  <= 1'b0;
        bit_cnt   <= '0;
        twp_abort <= 1'b1;
      end else begin
        case (twp_state)
          TWP_IDLE: begin
            conflict <= 1'b0;
            bit_cnt  <= '0;
            if (frame_start) twp_state <= TWP_CMD;
          end
          TWP_CMD: if (srise) begin
            twp_cmd   <= sda_in;
            bit_cnt   <= '0;
            twp_state <= TWP_ADDR;
          end
          TWP_ADDR: if (srise) begin
            twp_addr <= addr_next;
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              bit_cnt <= '0;
              if (addr_hit) conflict <= 1'b1;
              if (twp_cmd == CMD_WR) begin
                twp_state <= TWP_DATA;
              end else begin
                twp_shift <= mem[addr_next];
                twp_state <= TWP_TA;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TWP_DATA: if (srise) begin
            twp_shift <= {sda_in, twp_shift[DATA_W-1:1]};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt   <= '0;
              twp_state <= TWP_COMMIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TWP_COMMIT: twp_state <= TWP_IDLE;
          TWP_TA: if (srise) begin
            if (bit_cnt == CNT_W'(TA_CYC - 1)) begin
              bit_cnt   <= '0;
              sda_oe    <= 1'b1;
              sda_out   <= 1'b0;
              twp_state <= TWP_RSTART;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TWP_RSTART: if (srise) begin
            sda_out   <= twp_shift[0];
            twp_shift <= {1'b0, twp_shift[DATA_W-1:1]};
            twp_state <= TWP_RDATA;
          end
          TWP_RDATA: if (srise) begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt   <= '0;
              sda_oe    <= 1'b0;
              twp_state <= TWP_IDLE;
            end else begin
              sda_out   <= twp_shift[0];
              twp_shift <= {1'b0, twp_shift[DATA_W-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
          default: twp_state <= TWP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_twp_rim_regfile.sv
// Directed bench: two instances (RIM priority and TWP priority) share all stimulus.
module tb_twp_rim_regfile;

  localparam int H      = 4;
  localparam int TO_CYC = 1024;

  typedef struct {
    logic [31:0] v;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCL = 1'b0;
  logic        tb_sda = 1'b1;
  logic        tb_sda_oe = 1'b1;
  logic        cfg_req = 1'b0;
  logic        cfg_cmd = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  wire         sda_a, sda_b;
  logic        cfg_rdy_a, cfg_rdy_b, twp_busy_a, twp_busy_b, twp_abort_a, twp_abort_b;
  logic [15:0] cfg_rdata_a, cfg_rdata_b;

  logic [15:0] model_a [256];
  logic [15:0] model_b [256];
  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;

  assign sda_a = tb_sda_oe ? tb_sda : 1'bz;
  assign sda_b = tb_sda_oe ? tb_sda : 1'bz;
  pullup (sda_a);
  pullup (sda_b);

  always #5 clk = ~clk;

  twp_rim_regfile #(.PRIO_RIM(1), .TO_CYC(TO_CYC)) u_dut (
    .clk(clk), .reset_n(reset_n), .SCL(SCL), .SDA(sda_a),
    .cfg_req(cfg_req), .cfg_rdy(cfg_rdy_a), .cfg_cmd(cfg_cmd), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata_a),
    .twp_busy(twp_busy_a), .twp_abort(twp_abort_a)
  );

  twp_rim_regfile #(.PRIO_RIM(0), .TO_CYC(TO_CYC)) u_dut_p0 (
    .clk(clk), .reset_n(reset_n), .SCL(SCL), .SDA(sda_b),
    .cfg_req(cfg_req), .cfg_rdy(cfg_rdy_b), .cfg_cmd(cfg_cmd), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata_b),
    .twp_busy(twp_busy_b), .twp_abort(twp_abort_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.v);
    end
  endtask

  // One RIM transaction; cfg_rdy must be high exactly two cycles.
  task automatic rim_xact(input logic cmd, input logic [7:0] addr, input logic [15:0] wdata,
                          input string tag);
    int rdy;
    rdy = 0;
    @(negedge clk);
    cfg_req = 1'b1; cfg_cmd = cmd; cfg_addr = addr; cfg_wdata = wdata;
    if (cmd) begin
      model_a[addr] = wdata;
      model_b[addr] = wdata;
    end else begin
      sb_push({tag, "_rdata_a"}, 32'(model_a[addr]));
      sb_push({tag, "_rdata_b"}, 32'(model_b[addr]));
    end
    @(negedge clk);
    cfg_req = 1'b0;
    rdy += int'(cfg_rdy_a);
    if (!cmd) check({tag, "_rdata_rdy"}, 32'(cfg_rdata_a), 32'd0);
    @(negedge clk);
    rdy += int'(cfg_rdy_a);
    if (!cmd) begin
      sb_check(32'(cfg_rdata_a));
      sb_check(32'(cfg_rdata_b));
    end
    @(negedge clk);
    rdy += int'(cfg_rdy_a);
    if (!cmd) check({tag, "_rdata_after"}, 32'(cfg_rdata_a), 32'd0);
    @(negedge clk);
    rdy += int'(cfg_rdy_a);
    check({tag, "_rdy_cycles"}, 32'(rdy), 32'd2);
  endtask

  // One serial bit: data set while SCL low, then a full SCL period.
  task automatic twp_bit(input logic b, input bit chk_commit);
    @(negedge clk);
    tb_sda = b;
    repeat (H) @(negedge clk);
    SCL = 1'b1;
    if (chk_commit) begin
      @(negedge clk);
      @(negedge clk);
      check("busy_in_commit", 32'(twp_busy_a), 32'd1);
      @(negedge clk);
      check("busy_after_commit", 32'(twp_busy_a), 32'd0);
      repeat (H - 3) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    SCL = 1'b0;
  endtask

  task automatic twp_pulse();
    @(negedge clk);
    SCL = 1'b1;
    repeat (H) @(negedge clk);
    SCL = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic twp_header(input logic cmd, input logic [7:0] addr, input int nbits);
    twp_bit(1'b0, 1'b0);
    twp_bit(cmd, 1'b0);
    for (int i = 0; i < nbits; i++) twp_bit(addr[i], 1'b0);
  endtask

  // Write frame; optionally a RIM write to the same register lands mid-DATA.
  task automatic twp_write(input logic [7:0] addr, input logic [15:0] data,
                           input bit mid_rim, input logic [15:0] rim_data);
    twp_header(1'b1, addr, 8);
    for (int i = 0; i < 16; i++) begin
      if (mid_rim && i == 8) rim_xact(1'b1, addr, rim_data, "mid_rim_wr");
      twp_bit(data[i], i == 15);
    end
    @(negedge clk);
    tb_sda = 1'b1;
    model_a[addr] = mid_rim ? rim_data : data;
    model_b[addr] = data;
  endtask

  // Read frame: released during TA1, start bit after TA2, 16 data bits, then released.
  task automatic twp_read(input logic [7:0] addr, input string tag);
    logic [15:0] v;
    v = model_a[addr];
    twp_header(1'b0, addr, 8);
    tb_sda_oe = 1'b0;
    sb_push({tag, "_ta1"}, 32'd1);
    sb_push({tag, "_start"}, 32'd0);
    for (int i = 0; i < 16; i++) sb_push($sformatf("%s_bit%0d", tag, i), 32'(v[i]));
    sb_push({tag, "_release"}, 32'd1);
    for (int i = 0; i < 19; i++) begin
      twp_pulse();
      sb_check(32'(sda_a));
    end
    check({tag, "_busy_end"}, 32'(twp_busy_a), 32'd0);
    tb_sda = 1'b1;
    tb_sda_oe = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int abort_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    tb_sda_oe = 1'b0;
    @(negedge clk);
    check("rst_cfg_rdy", 32'(cfg_rdy_a), 32'd0);
    check("rst_cfg_rdata", 32'(cfg_rdata_a), 32'd0);
    check("rst_busy", 32'(twp_busy_a), 32'd0);
    check("rst_abort", 32'(twp_abort_a), 32'd0);
    check("rst_sda_released", 32'(sda_a), 32'd1);
    tb_sda_oe = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // RIM write then read
    rim_xact(1'b1, 8'h12, 16'hBEEF, "rim_wr12");
    rim_xact(1'b0, 8'h12, 16'h0000, "rim_rd12");

    // TWP write, RIM read back
    twp_write(8'h34, 16'hA5C3, 1'b0, 16'h0000);
    rim_xact(1'b0, 8'h34, 16'h0000, "rim_rd34_twp");

    // TWP read of a preloaded register
    rim_xact(1'b1, 8'h34, 16'h1234, "rim_wr34");
    twp_read(8'h34, "twp_rd34");

    // Same-address conflict: RIM write lands mid-DATA of a TWP write
    twp_write(8'h40, 16'h5555, 1'b1, 16'h0F0F);
    rim_xact(1'b0, 8'h40, 16'h0000, "prio_rd40");

    // Mid-frame timeout after 5 address bits
    rim_xact(1'b1, 8'h50, 16'h7777, "rim_wr50");
    twp_header(1'b1, 8'h50, 5);
    abort_cnt = 0;
    for (int i = 0; i < TO_CYC + 5; i++) begin
      @(negedge clk);
      abort_cnt += int'(twp_abort_a);
    end
    check("to_abort_pulses", 32'(abort_cnt), 32'd1);
    check("to_busy", 32'(twp_busy_a), 32'd0);
    tb_sda = 1'b1;
    rim_xact(1'b0, 8'h50, 16'h0000, "to_rd50_unchanged");
    twp_write(8'h51, 16'h3C3C, 1'b0, 16'h0000);
    rim_xact(1'b0, 8'h51, 16'h0000, "to_rd51_next");

    // Reset for one cycle in the middle of a read response
    twp_header(1'b0, 8'h34, 8);
    tb_sda_oe = 1'b0;
    twp_pulse();
    twp_pulse();
    twp_pulse();
    check("rstmid_sda_bit0", 32'(sda_a), 32'd0);
    @(negedge clk);
    cfg_req = 1'b1; cfg_cmd = 1'b0; cfg_addr = 8'h12;
    @(negedge clk);
    cfg_req = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rstmid_sda_released", 32'(sda_a), 32'd1);
    check("rstmid_cfg_rdy", 32'(cfg_rdy_a), 32'd0);
    check("rstmid_busy", 32'(twp_busy_a), 32'd0);
    check("rstmid_rdata", 32'(cfg_rdata_a), 32'd0);
    @(negedge clk);
    check("rstmid_cfg_rdy_idle", 32'(cfg_rdy_a), 32'd0);
    tb_sda = 1'b1;
    tb_sda_oe = 1'b1;
    rim_xact(1'b0, 8'h34, 16'h0000, "rstmid_rd34");
    twp_read(8'h12, "twp_rd12");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
